id_ex_pipe_reg: RTL and testbench

- ID/EX pipeline register of the five-stage MIPS pipeline. It sits directly downstream of the instruction decoder.
- Latches the decoder's control bundle together with operands, PC, IR and register numbers, and presents them to EX.
- Detects load-use hazards against the instruction currently held in EX and inserts bubbles on hazard or branch flush.
- Keeps a saturating bubble counter for the on-board statistics display.

---
 rtl/id_ex_pipe_reg.sv | 237 +++++++++++++++++++++++
 tb/tb_id_ex_pipe_reg.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register: latches the decoded control bundle and operands for EX,
// detects load-use hazards against EX, inserts bubbles and counts them (saturating).
module id_ex_pipe_reg #(
  parameter int DW    = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             halt,
  input  logic             flush,
  input  logic             id_syscall,
  input  logic             id_jr,
  input  logic             id_jal,
  input  logic             id_j,
  input  logic             id_bne,
  input  logic             id_beq,
  input  logic             id_blez,
  input  logic             id_sh,
  input  logic             id_memwrite,
  input  logic             id_memtoreg,
  input  logic             id_regwrite,
  input  logic             id_alusrc,
  input  logic             id_regdst,
  input  logic [3:0]       id_aluop,
  input  logic [1:0]       id_extop,
  input  logic [DW-1:0]    id_pc,
  input  logic [DW-1:0]    id_ir,
  input  logic [DW-1:0]    id_rs_data,
  input  logic [DW-1:0]    id_rt_data,
  input  logic [DW-1:0]    id_imm,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic [4:0]       id_rd,
  output logic             ex_syscall,
  output logic             ex_jr,
  output logic             ex_jal,
  output logic             ex_j,
  output logic             ex_bne,
  output logic             ex_beq,
  output logic             ex_blez,
  output logic             ex_sh,
  output logic             ex_memwrite,
  output logic             ex_memtoreg,
  output logic             ex_regwrite,
  output logic             ex_alusrc,
  output logic             ex_regdst,
  output logic [3:0]       ex_aluop,
  output logic [1:0]       ex_extop,
  output logic [DW-1:0]    ex_pc,
  output logic [DW-1:0]    ex_ir,
  output logic [DW-1:0]    ex_rs_data,
  output logic [DW-1:0]    ex_rt_data,
  output logic [DW-1:0]    ex_imm,
  output logic [4:0]       ex_rs,
  output logic [4:0]       ex_rt,
  output logic [4:0]       ex_rd,
  output logic             ex_valid,
  output logic [4:0]       ex_dest,
  output logic             load_use_stall,
  output logic [CNT_W-1:0] bubble_cnt
);

  typedef struct packed {
    logic       syscall;
    logic       jr;
    logic       jal;
    logic       j;
    logic       bne;
    logic       beq;
    logic       blez;
    logic       sh;
    logic       memwrite;
    logic       memtoreg;
    logic       regwrite;
    logic       alusrc;
    logic       regdst;
    logic [3:0] aluop;
    logic [1:0] extop;
  } ctrl_t;

  typedef struct packed {
    logic [DW-1:0] pc;
    logic [DW-1:0] ir;
    logic [DW-1:0] rs_data;
    logic [DW-1:0] rt_data;
    logic [DW-1:0] imm;
    logic [4:0]    rs;
    logic [4:0]    rt;
    logic [4:0]    rd;
  } data_t;

  // Per-cycle update decision, in priority order halt > bubble > load.
  typedef enum logic [1:0] {
    UPD_HOLD   = 2'd0,
    UPD_BUBBLE = 2'd1,
    UPD_LOAD   = 2'd2
  } upd_t;

  ctrl_t            id_ctrl;
  data_t            id_data;
  ctrl_t            ex_ctrl_q;
  data_t            ex_data_q;
  logic             ex_valid_q;
  logic [4:0]       ex_dest_q;
  logic [CNT_W-1:0] bubble_cnt_q;
  logic [CNT_W-1:0] bubble_cnt_inc;
  logic [4:0]       id_dest;
  logic             hazard;
  upd_t             upd;

  assign id_ctrl = '{
    syscall:  id_syscall,
    jr:       id_jr,
    jal:      id_jal,
    j:        id_j,
    bne:      id_bne,
    beq:      id_beq,
    blez:     id_blez,
    sh:       id_sh,
    memwrite: id_memwrite,
    memtoreg: id_memtoreg,
    regwrite: id_regwrite,
    alusrc:   id_alusrc,
    regdst:   id_regdst,
    aluop:    id_aluop,
    extop:    id_extop
  };

  assign id_data = '{
    pc:      id_pc,
    ir:      id_ir,
    rs_data: id_rs_data,
    rt_data: id_rt_data,
    imm:     id_imm,
    rs:      id_rs,
    rt:      id_rt,
    rd:      id_rd
  };

  // jal always links into $31, independent of the rd field.
  always_comb begin
    id_dest = id_rt;
    if (id_jal) begin
      id_dest = 5'd31;
    end else if (id_regdst) begin
      id_dest = id_rd;
    end
  end

  // Conservative: rs and rt are compared even if the ID instruction ignores them.
  always_comb begin
    hazard = 1'b0;
    if (ex_valid_q && ex_ctrl_q.memtoreg && ex_ctrl_q.regwrite && (ex_dest_q != 5'd0)) begin
      hazard = (ex_dest_q == id_rs) || (ex_dest_q == id_rt);
    end
  end

  assign load_use_stall = hazard;

  always_comb begin
    upd = UPD_LOAD;
    if (halt) begin
      upd = UPD_HOLD;
    end else if (flush || hazard) begin
      upd = UPD_BUBBLE;
    end
  end

  // Saturating increment: stays at all-ones once reached.
  always_comb begin
    bubble_cnt_inc = bubble_cnt_q;
    if (bubble_cnt_q != {CNT_W{1'b1}}) begin
      bubble_cnt_inc = bubble_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_ctrl_q    <= '0;
      ex_data_q    <= '0;
      ex_valid_q   <= 1'b0;
      ex_dest_q    <= 5'd0;
      bubble_cnt_q <= '0;
    end else begin
      case (upd)
        UPD_BUBBLE: begin
          ex_ctrl_q    <= '0;
          ex_data_q    <= '0;
          ex_valid_q   <= 1'b0;
          ex_dest_q    <= 5'd0;
          bubble_cnt_q <= bubble_cnt_inc;
        end
        UPD_LOAD: begin
          ex_ctrl_q  <= id_ctrl;
          ex_data_q  <= id_data;
          ex_valid_q <= 1'b1;
          ex_dest_q  <= id_dest;
        end
        default: begin
          ex_ctrl_q    <= ex_ctrl_q;
          ex_data_q    <= ex_data_q;
          ex_valid_q   <= ex_valid_q;
          ex_dest_q    <= ex_dest_q;
          bubble_cnt_q <= bubble_cnt_q;
        end
      endcase
    end
  end

  assign ex_syscall  = ex_ctrl_q.syscall;
  assign ex_jr       = ex_ctrl_q.jr;
  assign ex_jal      = ex_ctrl_q.jal;
  assign ex_j        = ex_ctrl_q.j;
  assign ex_bne      = ex_ctrl_q.bne;
  assign ex_beq      = ex_ctrl_q.beq;
  assign ex_blez     = ex_ctrl_q.blez;
  assign ex_sh       = ex_ctrl_q.sh;
  assign ex_memwrite = ex_ctrl_q.memwrite;
  assign ex_memtoreg = ex_ctrl_q.memtoreg;
  assign ex_regwrite = ex_ctrl_q.regwrite;
  assign ex_alusrc   = ex_ctrl_q.alusrc;
  assign ex_regdst   = ex_ctrl_q.regdst;
  assign ex_aluop    = ex_ctrl_q.aluop;
  assign ex_extop    = ex_ctrl_q.extop;
  assign ex_pc       = ex_data_q.pc;
  assign ex_ir       = ex_data_q.ir;
  assign ex_rs_data  = ex_data_q.rs_data;
  assign ex_rt_data  = ex_data_q.rt_data;
  assign ex_imm      = ex_data_q.imm;
  assign ex_rs       = ex_data_q.rs;
  assign ex_rt       = ex_data_q.rt;
  assign ex_rd       = ex_data_q.rd;
  assign ex_valid    = ex_valid_q;
  assign ex_dest     = ex_dest_q;
  assign bubble_cnt  = bubble_cnt_q;

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Bench for id_ex_pipe_reg: directed scenarios plus randomized traffic checked
// against an instruction-level model of what EX should hold.
module tb_id_ex_pipe_reg;

  localparam int DW    = 32;
  localparam int CNT_W = 6;
  localparam int CMAX  = (1 << CNT_W) - 1;

  typedef struct packed {
    logic          syscall, jr, jal, j, bne, beq, blez, sh;
    logic          memwrite, memtoreg, regwrite, alusrc, regdst;
    logic [3:0]    aluop;
    logic [1:0]    extop;
    logic [DW-1:0] pc, ir, rs_data, rt_data, imm;
    logic [4:0]    rs, rt, rd;
  } instr_t;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic halt = 1'b0;
  logic flush = 1'b0;
  always #5 clk = ~clk;

  instr_t           id_in = '0;
  instr_t           ex_obs;
  logic             ex_valid;
  logic [4:0]       ex_dest;
  logic             load_use_stall;
  logic [CNT_W-1:0] bubble_cnt;

  // model state
  instr_t exp_ex;
  logic   exp_valid;
  logic [4:0] exp_dest;
  int     exp_cnt;
  int     errors = 0;
  int     checks = 0;

  id_ex_pipe_reg #(.DW(DW), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .halt(halt), .flush(flush),
    .id_syscall(id_in.syscall), .id_jr(id_in.jr), .id_jal(id_in.jal), .id_j(id_in.j),
    .id_bne(id_in.bne), .id_beq(id_in.beq), .id_blez(id_in.blez), .id_sh(id_in.sh),
    .id_memwrite(id_in.memwrite), .id_memtoreg(id_in.memtoreg), .id_regwrite(id_in.regwrite),
    .id_alusrc(id_in.alusrc), .id_regdst(id_in.regdst), .id_aluop(id_in.aluop),
    .id_extop(id_in.extop), .id_pc(id_in.pc), .id_ir(id_in.ir), .id_rs_data(id_in.rs_data),
    .id_rt_data(id_in.rt_data), .id_imm(id_in.imm), .id_rs(id_in.rs), .id_rt(id_in.rt),
    .id_rd(id_in.rd),
    .ex_syscall(ex_obs.syscall), .ex_jr(ex_obs.jr), .ex_jal(ex_obs.jal), .ex_j(ex_obs.j),
    .ex_bne(ex_obs.bne), .ex_beq(ex_obs.beq), .ex_blez(ex_obs.blez), .ex_sh(ex_obs.sh),
    .ex_memwrite(ex_obs.memwrite), .ex_memtoreg(ex_obs.memtoreg), .ex_regwrite(ex_obs.regwrite),
    .ex_alusrc(ex_obs.alusrc), .ex_regdst(ex_obs.regdst), .ex_aluop(ex_obs.aluop),
    .ex_extop(ex_obs.extop), .ex_pc(ex_obs.pc), .ex_ir(ex_obs.ir), .ex_rs_data(ex_obs.rs_data),
    .ex_rt_data(ex_obs.rt_data), .ex_imm(ex_obs.imm), .ex_rs(ex_obs.rs), .ex_rt(ex_obs.rt),
    .ex_rd(ex_obs.rd),
    .ex_valid(ex_valid), .ex_dest(ex_dest), .load_use_stall(load_use_stall),
    .bubble_cnt(bubble_cnt)
  );

  // ---------------- reference model ----------------
  function automatic logic [4:0] dest_of(instr_t i);
    if (i.jal) return 5'd31;
    return i.regdst ? i.rd : i.rt;
  endfunction

  // A load in EX blocks any ID instruction naming its (nonzero) target.
  function automatic logic model_stall();
    if (!exp_valid || !exp_ex.memtoreg || !exp_ex.regwrite || exp_dest == 5'd0) return 1'b0;
    return (exp_dest == id_in.rs) || (exp_dest == id_in.rt);
  endfunction

  task automatic model_reset();
    exp_ex = '0; exp_valid = 1'b0; exp_dest = 5'd0; exp_cnt = 0;
  endtask

  // One clock: model sees the same pre-edge inputs as the DUT; returns at edge+1.
  task automatic step();
    instr_t nxt_in;
    logic   st;
    nxt_in = id_in;
    st = model_stall();
    @(posedge clk);
    if (!halt) begin
      if (flush || st) begin
        exp_ex = '0; exp_valid = 1'b0; exp_dest = 5'd0;
        exp_cnt = (exp_cnt < CMAX) ? exp_cnt + 1 : CMAX;
      end else begin
        exp_ex = nxt_in; exp_valid = 1'b1; exp_dest = dest_of(nxt_in);
      end
    end
    #1;
  endtask

  function automatic instr_t rand_instr();
    instr_t i;
    i = '0;
    {i.syscall, i.jr, i.jal, i.j, i.bne, i.beq, i.blez, i.sh} = 8'($urandom);
    i.jal      = ($urandom_range(0, 7) == 0);
    i.memwrite = 1'($urandom);
    i.memtoreg = 1'($urandom);
    i.regwrite = ($urandom_range(0, 3) != 0);
    i.alusrc   = 1'($urandom);
    i.regdst   = 1'($urandom);
    i.aluop    = 4'($urandom);
    i.extop    = 2'($urandom);
    i.pc       = $urandom; i.ir = $urandom; i.rs_data = $urandom;
    i.rt_data  = $urandom; i.imm = $urandom;
    i.rs = 5'($urandom_range(0, 7));
    i.rt = 5'($urandom_range(0, 7));
    i.rd = ($urandom_range(0, 9) == 0) ? 5'd31 : 5'($urandom_range(0, 7));
    return i;
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; model_reset();
    #2;
    if (ex_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", ex_valid); end
    checks++;
    if (bubble_cnt !== '0) begin errors++; $display("FAIL reset_cnt: got %0d want 0", bubble_cnt); end
    checks++;
    @(negedge clk); rst = 1'b0;
    id_in = rand_instr(); id_in.memtoreg = 1'b0;
    step();
    flush = 1'b1; step(); flush = 1'b0;
    id_in = rand_instr(); id_in.memtoreg = 1'b0;
    step();
    // asynchronous reset between edges
    #1 rst = 1'b1;
    #1;
    model_reset();
    if (ex_obs !== instr_t'('0)) begin errors++; $display("FAIL async_reset_ex: got %h want 0", ex_obs); end
    checks++;
    if (ex_valid !== 1'b0 || ex_dest !== 5'd0) begin
      errors++; $display("FAIL async_reset_valid_dest: got %b/%0d want 0/0", ex_valid, ex_dest);
    end
    checks++;
    if (bubble_cnt !== '0) begin errors++; $display("FAIL async_reset_cnt: got %0d want 0", bubble_cnt); end
    checks++;
    #1 rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_pass_through();
    id_in = '0; id_in.regdst = 1'b1; id_in.regwrite = 1'b1; id_in.aluop = 4'b0101;
    id_in.rs = 5'd1; id_in.rt = 5'd2; id_in.rd = 5'd3; id_in.pc = 32'h0040_0010;
    step();
    if (ex_aluop_chk() !== 4'b0101) begin errors++; $display("FAIL pass_aluop: got %b want 0101", ex_obs.aluop); end
    checks++;
    if (ex_dest !== 5'd3) begin errors++; $display("FAIL pass_dest: got %0d want 3", ex_dest); end
    checks++;
    if (ex_valid !== 1'b1 || load_use_stall !== 1'b0) begin
      errors++; $display("FAIL pass_valid_stall: got %b/%b want 1/0", ex_valid, load_use_stall);
    end
    checks++;
    if (ex_obs.pc !== 32'h0040_0010) begin errors++; $display("FAIL pass_pc: got %h want 00400010", ex_obs.pc); end
    checks++;
  endtask

  function automatic logic [3:0] ex_aluop_chk();
    return ex_obs.aluop;
  endfunction

  task automatic test_load_use();
    int c0;
    id_in = '0; id_in.memtoreg = 1'b1; id_in.regwrite = 1'b1; id_in.alusrc = 1'b1;
    id_in.rs = 5'd1; id_in.rt = 5'd5;
    step();
    c0 = exp_cnt;
    id_in = '0; id_in.regdst = 1'b1; id_in.regwrite = 1'b1; id_in.rs = 5'd5; id_in.rt = 5'd6; id_in.rd = 5'd7;
    #1;
    if (load_use_stall !== 1'b1) begin errors++; $display("FAIL lu_stall_on: got %b want 1", load_use_stall); end
    checks++;
    step();
    if (ex_valid !== 1'b0 || bubble_cnt !== CNT_W'(c0 + 1)) begin
      errors++; $display("FAIL lu_bubble: got valid=%b cnt=%0d want 0/%0d", ex_valid, bubble_cnt, c0 + 1);
    end
    checks++;
    if (load_use_stall !== 1'b0) begin errors++; $display("FAIL lu_stall_off: got %b want 0", load_use_stall); end
    checks++;
    step();
    if (ex_valid !== 1'b1 || ex_dest !== 5'd7 || ex_obs.rs !== 5'd5) begin
      errors++; $display("FAIL lu_dependent: got valid=%b dest=%0d rs=%0d want 1/7/5", ex_valid, ex_dest, ex_obs.rs);
    end
    checks++;
    // reset asserted while a stall is pending
    id_in = '0; id_in.memtoreg = 1'b1; id_in.regwrite = 1'b1; id_in.rt = 5'd9;
    step();
    id_in = '0; id_in.rt = 5'd9;
    #1;
    if (load_use_stall !== 1'b1) begin errors++; $display("FAIL lu_rst_pre: got %b want 1", load_use_stall); end
    checks++;
    rst = 1'b1; #1;
    model_reset();
    if (load_use_stall !== 1'b0 || ex_valid !== 1'b0) begin
      errors++; $display("FAIL lu_rst_drop: got stall=%b valid=%b want 0/0", load_use_stall, ex_valid);
    end
    checks++;
    #1 rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_zero_guard();
    id_in = '0; id_in.memtoreg = 1'b1; id_in.regwrite = 1'b1; id_in.rt = 5'd0; id_in.rs = 5'd4;
    step();
    id_in = '0; id_in.rs = 5'd0; id_in.rt = 5'd0; id_in.regdst = 1'b1; id_in.rd = 5'd8;
    #1;
    if (load_use_stall !== 1'b0) begin errors++; $display("FAIL zero_guard: got %b want 0", load_use_stall); end
    checks++;
    step();
    if (ex_valid !== 1'b1 || ex_dest !== 5'd8) begin
      errors++; $display("FAIL zero_guard_load: got %b/%0d want 1/8", ex_valid, ex_dest);
    end
    checks++;
    // jal links to $31 whatever rd says
    id_in = '0; id_in.jal = 1'b1; id_in.regwrite = 1'b1; id_in.regdst = 1'b1; id_in.rd = 5'd12;
    step();
    if (ex_dest !== 5'd31) begin errors++; $display("FAIL jal_dest: got %0d want 31", ex_dest); end
    checks++;
  endtask

  task automatic test_flush_stall();
    int c0;
    id_in = '0; id_in.memtoreg = 1'b1; id_in.regwrite = 1'b1; id_in.rt = 5'd4;
    step();
    c0 = exp_cnt;
    id_in = '0; id_in.rt = 5'd4; id_in.regwrite = 1'b1;
    flush = 1'b1;
    #1;
    if (load_use_stall !== 1'b1) begin errors++; $display("FAIL fs_hazard: got %b want 1", load_use_stall); end
    checks++;
    step();
    flush = 1'b0;
    if (ex_valid !== 1'b0 || bubble_cnt !== CNT_W'(c0 + 1)) begin
      errors++; $display("FAIL fs_single_bubble: got valid=%b cnt=%0d want 0/%0d", ex_valid, bubble_cnt, c0 + 1);
    end
    checks++;
    step();
    if (ex_valid !== 1'b1 || bubble_cnt !== CNT_W'(c0 + 1)) begin
      errors++; $display("FAIL fs_resume: got valid=%b cnt=%0d want 1/%0d", ex_valid, bubble_cnt, c0 + 1);
    end
    checks++;
  endtask

  task automatic test_halt();
    instr_t held;
    int c0;
    held = rand_instr(); held.memtoreg = 1'b1; held.regwrite = 1'b1; held.jal = 1'b0;
    held.regdst = 1'b0; held.rt = 5'd6;
    id_in = held;
    step();
    c0 = exp_cnt;
    halt = 1'b1;
    for (int k = 0; k < 3; k++) begin
      id_in = rand_instr(); id_in.rs = 5'd6;
      flush = (k == 1);
      step();
      if (ex_obs !== held || ex_valid !== 1'b1 || ex_dest !== 5'd6) begin
        errors++; $display("FAIL halt_hold[%0d]: got %h want %h", k, ex_obs, held);
      end
      checks++;
      if (bubble_cnt !== CNT_W'(c0)) begin errors++; $display("FAIL halt_cnt[%0d]: got %0d want %0d", k, bubble_cnt, c0); end
      checks++;
      if (load_use_stall !== 1'b1) begin errors++; $display("FAIL halt_stall[%0d]: got %b want 1", k, load_use_stall); end
      checks++;
    end
    halt = 1'b0; flush = 1'b0;
    step();
  endtask

  task automatic test_saturation();
    flush = 1'b1;
    for (int k = 0; k < CMAX + 20; k++) begin
      step();
      if (bubble_cnt !== CNT_W'(exp_cnt)) begin
        errors++; $display("FAIL sat_step[%0d]: got %0d want %0d", k, bubble_cnt, exp_cnt);
      end
      checks++;
    end
    flush = 1'b0;
    if (bubble_cnt !== {CNT_W{1'b1}}) begin errors++; $display("FAIL sat_final: got %0d want %0d", bubble_cnt, CMAX); end
    checks++;
  endtask

  task automatic test_random();
    logic exp_st;
    rst = 1'b1; #1 model_reset(); #1 rst = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 400; k++) begin
      id_in = rand_instr();
      halt  = ($urandom_range(0, 9) == 0);
      flush = ($urandom_range(0, 9) == 0);
      #1;
      exp_st = model_stall();
      if (load_use_stall !== exp_st) begin
        errors++; $display("FAIL rnd_stall[%0d]: got %b want %b", k, load_use_stall, exp_st);
      end
      checks++;
      step();
      if (ex_obs !== exp_ex) begin errors++; $display("FAIL rnd_ex[%0d]: got %h want %h", k, ex_obs, exp_ex); end
      checks++;
      if (ex_valid !== exp_valid || ex_dest !== exp_dest) begin
        errors++; $display("FAIL rnd_valid_dest[%0d]: got %b/%0d want %b/%0d", k, ex_valid, ex_dest, exp_valid, exp_dest);
      end
      checks++;
      if (bubble_cnt !== CNT_W'(exp_cnt)) begin
        errors++; $display("FAIL rnd_cnt[%0d]: got %0d want %0d", k, bubble_cnt, exp_cnt);
      end
      checks++;
    end
    halt = 1'b0; flush = 1'b0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_pass_through();
    test_load_use();
    test_zero_guard();
    test_flush_stall();
    test_halt();
    test_saturation();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Guard against a stuck run.
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

endmodule
